multi_led_blinker: RTL
======================

# multi_led_blinker

Parametrised multi-channel LED pattern generator for the blinking_led design. It drives NUM_CH LED outputs, each with its own mode (off, on, repeating blink, one-shot pulse), period and on-time, all set through a valid/ready configuration port. New settings on a running channel take effect only at that channel's next period boundary, so no LED ever shows a glitched partial period. The block sits between the board's control logic and the LED pins, and runs entirely in the `clk_in` domain.

## Interface
- NUM_CH, 4: number of LED channels, 1..16.
- CNT_W, 24: width of the period counter and of the period/on-time fields.
- CH_W, $clog2(NUM_CH) (minimum 1): width of the channel select.
- clk_in  input  1  system clock; all logic on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- en_in  input  1  global enable; when low, counters hold and LEDs are dark.
- cfg_valid_in  input  1  a configuration write is offered.
- cfg_ready_out  output  1  the addressed channel can accept a write.
- cfg_ch_in  input  CH_W  target channel.
- cfg_mode_in  input  2  mode: 0=OFF, 1=ON, 2=BLINK, 3=ONESHOT.
- cfg_period_in  input  CNT_W  P; the period is P+1 cycles.
- cfg_ontime_in  input  CNT_W  T; number of on-cycles per period.
- led_out  output  NUM_CH  LED drive, registered.
- wrap_out  output  NUM_CH  one-cycle pulse per channel at each period end, registered.

## Operation
- Per-channel state:
  - active registers: mode, P, T;
  - counter `cnt`;
  - shadow registers with a `pend` flag.
- Handshake:
  - `cfg_ready_out` is combinational and equals `!pend[cfg_ch_in]`.
  - A write is accepted on any edge where both valid and ready are high.
  - The write is stored into the shadow registers and sets `pend`.
- Channel select out of range (`cfg_ch_in >= NUM_CH`): ready is 1 and the write is dropped.
- When a pending write is applied:
  - Channel in OFF or ON: applied on the next edge after acceptance.
  - Channel in BLINK or ONESHOT: applied on the wrap edge (the edge with cnt==P and en_in=1).
  - On apply: active registers <= shadow, cnt <= 0, pend <= 0.
  - Ready returns high the cycle after apply.
- Counter, only when en_in=1 and mode is BLINK or ONESHOT: cnt <= (cnt==P) ? 0 : cnt+1.
  - P=0 wraps every cycle.
- LED decode, registered (one cycle after cnt):
  - OFF: 0.
  - ON: 1.
  - BLINK and ONESHOT: `cnt < T`.
  - T=0 gives always off; T>P gives solid on.
- ONESHOT: at its wrap edge the mode becomes OFF and cnt stays at 0. A pending write is applied on that same edge instead.
- en_in=0: led_out is forced to 0 on the next edge; cnt and all registers hold. Handshake acceptance is unaffected.
- wrap_out[c]: set to 1 on the edge after channel c wraps (BLINK, or ONESHOT completion), otherwise 0.
- Reset values:
  - mode=OFF, P=0, T=0, cnt=0, pend=0.
  - led_out=0, wrap_out=0, so cfg_ready_out=1.
- rst_in mid-pattern or mid-handshake: everything returns to reset values on that edge; a write offered in the same cycle is discarded.

## Timing
- Accept at edge k on an idle channel: apply at edge k+1, and led_out shows the new mode from edge k+2.
- BLINK steady state: led_out high for min(T,P+1) cycles, then low for the rest of the P+1 cycle period. wrap_out pulses every P+1 cycles with en_in=1.
- Write accepted on the same edge that applies an earlier pending write: impossible, because ready is low while pend=1.
- Channels are fully independent; simultaneous wraps on several channels are legal.

## Configuration
- `MULTI_LED_ACTIVE_LOW_EN` defined: led_out is the bitwise inverse of the decode above.
  - Reset value and en_in=0 value become all ones.
  - wrap_out is unchanged.
- Not defined: active-high, as described above.

## Test plan
All scenarios use NUM_CH=4, CNT_W=8.
- Reset: hold rst_in for 2 cycles -> led_out=4'b0000, wrap_out=4'b0000, cfg_ready_out=1.
- Ch0 BLINK with P=9, T=3, en_in=1 -> led_out[0] repeats 3 high / 7 low; wrap_out[0] pulses every 10 cycles; other channels stay 0.
- Ch1 ONESHOT with P=4, T=2 -> led_out[1] high 2 cycles then low 3; exactly one wrap_out[1] pulse; stays dark afterward.
- Ch0 running P=9, T=3; at cnt=2 write BLINK P=3, T=1 ->
  - ready low until the wrap;
  - a second write offered meanwhile is stalled;
  - the new 1-high/3-low pattern starts at the wrap.
- Edge values: T=0 gives always 0; T=200 with P=9 gives solid 1; P=0, T=1 gives solid 1 with wrap_out high every cycle; en_in low 5 cycles mid-period gives led 0, then the pattern resumes at the held cnt.
- With `MULTI_LED_ACTIVE_LOW_EN` defined: after reset led_out=4'b1111, and the ch0 P=9, T=3 pattern is inverted.

Source files
------------

// File: rtl/multi_led_blinker_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_led_blinker_if
// Purpose  : Configuration port of multi_led_blinker. Carries one
//            valid/ready write of {channel, mode, period, on-time}.
// Signals  : cfg_valid_in   - a configuration write is offered
//            cfg_ready_out  - addressed channel can accept the write
//            cfg_ch_in      - target channel (CH_W bits)
//            cfg_mode_in    - 0=OFF 1=ON 2=BLINK 3=ONESHOT
//            cfg_period_in  - P, period is P+1 cycles (CNT_W bits)
//            cfg_ontime_in  - T, on-cycles per period (CNT_W bits)
// Modports : master (configuration source), slave (the blinker)
// Revision : 1.0 - initial release
// ============================================================================
interface multi_led_blinker_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 24,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);

    logic             cfg_valid_in;
    logic             cfg_ready_out;
    logic [CH_W-1:0]  cfg_ch_in;
    logic [1:0]       cfg_mode_in;
    logic [CNT_W-1:0] cfg_period_in;
    logic [CNT_W-1:0] cfg_ontime_in;

    modport master (
        output cfg_valid_in,
        output cfg_ch_in,
        output cfg_mode_in,
        output cfg_period_in,
        output cfg_ontime_in,
        input  cfg_ready_out
    );

    modport slave (
        input  cfg_valid_in,
        input  cfg_ch_in,
        input  cfg_mode_in,
        input  cfg_period_in,
        input  cfg_ontime_in,
        output cfg_ready_out
    );

endinterface
`default_nettype wire

// File: rtl/multi_led_blinker.sv
`default_nettype none
// ============================================================================
// Module   : multi_led_blinker
// Purpose  : NUM_CH independent LED pattern generators (OFF, ON, repeating
//            BLINK, one-shot pulse). Each channel keeps an active and a
//            shadow configuration; a new setting on a counting channel is
//            only applied at that channel's period boundary so the LED never
//            shows a truncated period.
// Ports    : clk_in   - system clock, rising edge
//            rst_in   - synchronous active-high reset
//            en_in    - global enable; low holds counters and darkens LEDs
//            cfg      - configuration port (multi_led_blinker_if.slave)
//            led_out  - registered LED drive, one bit per channel
//            wrap_out - registered one-cycle pulse at each period end
// Options  : MULTI_LED_ACTIVE_LOW_EN - when defined, led_out is inverted
//            (dark level is 1, including reset and en_in=0); wrap_out is
//            unaffected.
// Revision : 1.0 - initial release
// ============================================================================
module multi_led_blinker #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 24,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  wire                 clk_in,
    input  wire                 rst_in,
    input  wire                 en_in,
    multi_led_blinker_if.slave  cfg,
    output logic [NUM_CH-1:0]   led_out,
    output logic [NUM_CH-1:0]   wrap_out
);

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_ON      = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_ONESHOT = 2'd3;

    // Every encodable channel select gets a slot so the ready lookup can
    // never index past the vector; unused slots read as "not pending",
    // which makes out-of-range writes look ready and vanish.
    localparam int SEL_N = 1 << CH_W;

`ifdef MULTI_LED_ACTIVE_LOW_EN
    localparam logic LED_DARK = 1'b1;
`else
    localparam logic LED_DARK = 1'b0;
`endif

    logic [NUM_CH-1:0] pend;
    logic [SEL_N-1:0]  pend_sel;

    for (genvar s = 0; s < SEL_N; s++) begin : g_sel
        if (s < NUM_CH) begin : g_live
            assign pend_sel[s] = pend[s];
        end else begin : g_pad
            assign pend_sel[s] = 1'b0;
        end
    end

    assign cfg.cfg_ready_out = !pend_sel[cfg.cfg_ch_in];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // active configuration and phase counter
        logic [1:0]       mode;
        logic [CNT_W-1:0] per;
        logic [CNT_W-1:0] ont;
        logic [CNT_W-1:0] cnt;
        // shadow configuration waiting for the next safe apply point
        logic [1:0]       sh_mode;
        logic [CNT_W-1:0] sh_per;
        logic [CNT_W-1:0] sh_ont;
        logic             pend_r;
        // output registers
        logic             led_r;
        logic             wrap_r;

        logic counting;
        logic wrap_now;
        logic hit;
        logic lit;

        assign counting = (mode == MODE_BLINK) || (mode == MODE_ONESHOT);
        assign wrap_now = en_in && counting && (cnt == per);
        // A matching select implies the channel is in range; ready for this
        // channel is exactly !pend_r.
        assign hit      = cfg.cfg_valid_in && !pend_r &&
                          (cfg.cfg_ch_in == CH_W'(c));
        // cnt < ont covers the corner cases naturally: T=0 never lights,
        // T>P lights for the whole period.
        assign lit      = (mode == MODE_ON) || (counting && (cnt < ont));

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                mode    <= MODE_OFF;
                per     <= '0;
                ont     <= '0;
                cnt     <= '0;
                sh_mode <= MODE_OFF;
                sh_per  <= '0;
                sh_ont  <= '0;
                pend_r  <= 1'b0;
                led_r   <= LED_DARK;
                wrap_r  <= 1'b0;
            end else begin
                wrap_r <= wrap_now;
                led_r  <= LED_DARK ^ (en_in & lit);

                if (pend_r && !counting) begin
                    // Static modes have no period to protect: apply at once.
                    mode   <= sh_mode;
                    per    <= sh_per;
                    ont    <= sh_ont;
                    cnt    <= '0;
                    pend_r <= 1'b0;
                end else if (wrap_now) begin
                    if (pend_r) begin
                        mode   <= sh_mode;
                        per    <= sh_per;
                        ont    <= sh_ont;
                        cnt    <= '0;
                        pend_r <= 1'b0;
                    end else begin
                        cnt <= '0;
                        // A one-shot retires itself after its single period.
                        if (mode == MODE_ONESHOT) begin
                            mode <= MODE_OFF;
                        end
                    end
                end else if (en_in && counting) begin
                    cnt <= cnt + CNT_W'(1);
                end

                // Acceptance needs pend_r low, so it never collides with an
                // apply (which needs pend_r high) on the same edge.
                if (hit) begin
                    sh_mode <= cfg.cfg_mode_in;
                    sh_per  <= cfg.cfg_period_in;
                    sh_ont  <= cfg.cfg_ontime_in;
                    pend_r  <= 1'b1;
                end
            end
        end

        assign pend[c]     = pend_r;
        assign led_out[c]  = led_r;
        assign wrap_out[c] = wrap_r;
    end

endmodule
`default_nettype wire
